// File: rtl/simon_pkg.sv
// Shared types and sizes for the Simon button front end.
// Provides the arbitration state enum and button-width constants.
package simon_pkg;

  localparam int NUM_BTNS = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LOCKOUT
  } state_e;

  // Index of the highest set bit; the caller guarantees one-hot input.
  function automatic logic [IDX_W-1:0] onehot_idx(
    input logic [NUM_BTNS-1:0] v
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// One button channel: 2-flop synchroniser plus stability counter.
// Ports: clk, reset (sync, active-high), btn (raw), deb (debounced level).
module btn_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic deb
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only runs while the synchronised input disagrees with deb;
  // it is cleared on toggle, so it can never wrap.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces four Simon buttons and arbitrates them into one press.
// Ports: clk, reset, btns in; num, pressed, press/release pulses, deb out.
module btn_debounce
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns,
  output logic [IDX_W-1:0]    num,
  output logic                pressed,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [NUM_BTNS-1:0] deb
);

  logic [NUM_BTNS-1:0] deb_w;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    btn_sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .btn  (btns[g]),
      .deb  (deb_w[g])
    );
  end

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] num_q;
  logic [IDX_W-1:0] num_d;
  logic             pressed_q;
  logic             pressed_d;
  logic             pp_q;
  logic             pp_d;
  logic             rp_q;
  logic             rp_d;
  logic             any_hi;
  logic             one_hi;

  assign any_hi = (deb_w != '0);
  assign one_hi = any_hi &&
                  ((deb_w & (deb_w - 1'b1)) == '0);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pp_d    = 1'b0;
    rp_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (one_hi) begin
          state_d = ST_PRESSED;
          num_d   = onehot_idx(deb_w);
          pp_d    = 1'b1;
        end else if (any_hi) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_PRESSED: begin
        if (!deb_w[num_q]) begin
          rp_d    = 1'b1;
          state_d = any_hi ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (!any_hi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pressed_d = (state_d == ST_PRESSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      pressed_q <= 1'b0;
      pp_q      <= 1'b0;
      rp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      pressed_q <= pressed_d;
      pp_q      <= pp_d;
      rp_q      <= rp_d;
    end
  end

  assign num           = num_q;
  assign pressed       = pressed_q;
  assign press_pulse   = pp_q;
  assign release_pulse = rp_q;
  assign deb           = deb_w;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with a short debounce window.
// Directed scenarios plus random traffic against a window-based model.
module tb_btn_debounce;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0;
  logic [1:0] num;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] deb;

  btn_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .btns         (btns),
    .num          (num),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .deb          (deb)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pp_cnt = 0;
  int rp_cnt = 0;
  int outstanding = 0;

  // Model: a channel flips when its last DC synchronised samples
  // all disagree with the current debounced level.
  logic [3:0]    m_sy1 = '0;
  logic [3:0]    m_sy2 = '0;
  logic [3:0]    m_deb = '0;
  logic [DC-1:0] m_win [4];
  int            m_mode = 0; // 0 free, 1 holding m_num, 2 locked
  logic [1:0]    m_num = '0;
  logic          m_pr = 1'b0;
  logic          m_pp = 1'b0;
  logic          m_rp = 1'b0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] b);
    logic [3:0] ndeb;
    int         ones;
    if (rst) begin
      m_sy1 = '0; m_sy2 = '0; m_deb = '0;
      for (int i = 0; i < 4; i++) m_win[i] = '0;
      m_mode = 0; m_num = '0;
      m_pr = 0; m_pp = 0; m_rp = 0;
      return;
    end
    ones = $countones(m_deb);
    m_pp = 0;
    m_rp = 0;
    if (m_mode == 0) begin
      if (ones == 1) begin
        m_mode = 1;
        m_pp = 1;
        for (int i = 0; i < 4; i++)
          if (m_deb[i]) m_num = 2'(i);
      end else if (ones > 1) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (!m_deb[m_num]) begin
        m_rp = 1;
        m_mode = (ones == 0) ? 0 : 2;
      end
    end else begin
      if (ones == 0) m_mode = 0;
    end
    m_pr = (m_mode == 1);
    ndeb = m_deb;
    for (int i = 0; i < 4; i++) begin
      m_win[i] = {m_win[i][DC-2:0], m_sy2[i]};
      if (m_win[i] == (m_deb[i] ? {DC{1'b0}} : {DC{1'b1}}))
        ndeb[i] = ~m_deb[i];
    end
    m_deb = ndeb;
    m_sy2 = m_sy1;
    m_sy1 = b;
  endtask

  task automatic step();
    logic       r;
    logic [3:0] b;
    @(posedge clk);
    r = reset;
    b = btns;
    model_edge(r, b);
    cyc++;
    #1;
    chk("outs", {7'b0, deb, num, pressed, press_pulse,
                 release_pulse},
        {7'b0, m_deb, m_num, m_pr, m_pp, m_rp});
    if (press_pulse || release_pulse)
      chk("pulse_excl", 16'(press_pulse & release_pulse), 0);
    if (press_pulse) begin
      chk("pp_order", 16'(outstanding), 0);
      outstanding = 1;
      pp_cnt++;
    end
    if (release_pulse) begin
      chk("rp_order", 16'(outstanding), 1);
      outstanding = 0;
      rp_cnt++;
    end
    if (r) outstanding = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pulse(input bit rel, input int maxc,
                            output int n);
    logic hit;
    n = 0;
    hit = 0;
    while (!hit && n < maxc) begin
      step();
      n++;
      hit = rel ? release_pulse : press_pulse;
    end
    chk(rel ? "rp_seen" : "pp_seen", 16'(hit), 1);
  endtask

  int n;
  int p0;
  int r0;
  logic [3:0] deb_or;
  logic       pr_or;

  initial begin
    for (int i = 0; i < 4; i++) m_win[i] = '0;
    steps(3);
    chk("reset_outs", {7'b0, deb, num, pressed, press_pulse,
                       release_pulse}, 0);
    reset = 0;
    steps(2);

    // Clean press of button 2
    btns = 4'b0100;
    wait_pulse(0, 20, n);
    chk("t1_pp_lat", 16'(n), 7);
    chk("t1_num", 16'(num), 2);
    chk("t1_pressed", 16'(pressed), 1);
    steps(20 - n);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    chk("t1_rp_lat", 16'(n), 7);
    chk("t1_released", 16'(pressed), 0);
    steps(5);

    // Bounce on button 0: highs too short to be accepted
    p0 = pp_cnt;
    r0 = rp_cnt;
    deb_or = '0;
    for (int k = 0; k < 6; k++) begin
      btns = 4'b0001;
      for (int j = 0; j < 3; j++) begin
        step();
        deb_or = deb_or | deb;
      end
      btns = 4'b0000;
      for (int j = 0; j < 2; j++) begin
        step();
        deb_or = deb_or | deb;
      end
    end
    chk("t2_deb_quiet", 16'(deb_or), 0);
    chk("t2_no_pulse", 16'(pp_cnt + rp_cnt - p0 - r0), 0);
    btns = 4'b0001;
    p0 = pp_cnt;
    wait_pulse(0, 20, n);
    chk("t2_num", 16'(num), 0);
    steps(10);
    chk("t2_one_pp", 16'(pp_cnt - p0), 1);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    steps(3);

    // Simultaneous press is locked out
    p0 = pp_cnt;
    pr_or = 0;
    btns = 4'b0011;
    for (int j = 0; j < 15; j++) begin
      step();
      pr_or = pr_or | pressed;
    end
    chk("t3_deb", 16'(deb), 16'h3);
    chk("t3_no_pp", 16'(pp_cnt - p0), 0);
    chk("t3_no_pressed", 16'(pr_or), 0);
    btns = 4'b0;
    steps(10);
    btns = 4'b1000;
    wait_pulse(0, 20, n);
    chk("t3_num", 16'(num), 3);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    steps(3);

    // Second button while first held
    btns = 4'b0010;
    wait_pulse(0, 20, n);
    chk("t4_num", 16'(num), 1);
    p0 = pp_cnt;
    btns = 4'b0110;
    steps(15);
    chk("t4_no_pp", 16'(pp_cnt - p0), 0);
    chk("t4_held", 16'(pressed), 1);
    btns = 4'b0100;
    wait_pulse(1, 20, n);
    chk("t4_rp_lat", 16'(n), 7);
    steps(2);
    chk("t4_lock_pr", 16'(pressed), 0);
    p0 = pp_cnt;
    r0 = rp_cnt;
    btns = 4'b0;
    steps(15);
    chk("t4_quiet", 16'(pp_cnt + rp_cnt - p0 - r0), 0);
    chk("t4_deb0", 16'(deb), 0);

    // Reset mid-press
    btns = 4'b0100;
    wait_pulse(0, 20, n);
    reset = 1;
    step();
    chk("t5_rst_outs", {7'b0, deb, num, pressed, press_pulse,
                        release_pulse}, 0);
    reset = 0;
    wait_pulse(0, 20, n);
    chk("t5_pp_lat", 16'(n), 7);
    chk("t5_num", 16'(num), 2);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    steps(3);

    // Back-to-back presses
    btns = 4'b0001;
    wait_pulse(0, 20, n);
    chk("t6_num0", 16'(num), 0);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    steps(10);
    chk("t6_num_hold", 16'(num), 0);
    btns = 4'b0010;
    wait_pulse(0, 20, n);
    chk("t6_num1", 16'(num), 1);
    btns = 4'b0;
    wait_pulse(1, 20, n);
    steps(3);

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      btns = 4'($urandom);
      if ($urandom_range(0, 24) == 0) reset = 1;
      step();
      reset = 0;
      steps(int'($urandom_range(0, 12)));
    end
    btns = 4'b0;
    steps(20);
    chk("end_idle", {12'b0, deb}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
